// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants and types for the traffic countdown display.
// Segment codes {g,f,e,d,c,b,a} active-low, digit slot indices, converter states.
package traffic_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Scan order: index 0 drives an[3], index 3 drives an[0].
    localparam logic [1:0] DIG_R1_TENS = 2'd0;
    localparam logic [1:0] DIG_R1_ONES = 2'd1;
    localparam logic [1:0] DIG_R2_TENS = 2'd2;
    localparam logic [1:0] DIG_R2_ONES = 2'd3;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        UPDATE
    } conv_state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        if (d > 4'd9) s = SEG_BLANK;
        else          s = SEG_DIGIT[d];
        return s;
    endfunction

endpackage

// File: rtl/traffic_display_bin2bcd.sv
// bin2bcd_seq: 8-bit sequential double-dabble, one shift per cycle.
// Ports: clk, rs (async high), i_start, i_bin[7:0] -> o_bcd[11:0], o_done pulse.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rs,
    input  logic        i_start,
    input  logic [7:0]  i_bin,
    output logic [11:0] o_bcd,
    output logic        o_done
);

    logic [19:0] r_sh;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_done;

    // Add 3 to every BCD nibble >= 5, then shift the whole word left.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        if (v[19:16] >= 4'd5) t[19:16] = v[19:16] + 4'd3;
        if (v[15:12] >= 4'd5) t[15:12] = v[15:12] + 4'd3;
        if (v[11:8]  >= 4'd5) t[11:8]  = v[11:8]  + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_sh   <= {12'd0, i_bin};
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_sh  <= dd_step(r_sh);
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_bcd  = r_sh[19:8];
    assign o_done = r_done;

endmodule

// File: rtl/traffic_display.sv
// traffic_display: shows two binary countdowns on a 4-digit mux'd 7-seg.
// Ports: clk, rs, counter1/2[7:0] in; an[3:0], seg[6:0], dp, upd out.
module traffic_display
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [7:0] counter1,
    input  logic [7:0] counter2,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       upd
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    conv_state_t   r_state, w_state_nxt;
    logic [2:0]    r_cnt, w_cnt_nxt;
    logic          w_start;
    logic [11:0]   w_bcd1, w_bcd2;
    logic          w_done1, w_done2;
    logic          w_wr;
    logic [11:0]   r_disp1, r_disp2;
    logic [11:0]   w_disp1_nxt, w_disp2_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [1:0]    r_dig, w_dig_nxt;
    logic [11:0]   w_sel;
    logic          w_tens_slot;
    logic [3:0]    w_digit;
    logic [3:0]    w_an_sel;
    logic [3:0]    w_an, r_an;
    logic [6:0]    w_seg, r_seg;
    logic          r_upd;

    bin2bcd_seq u_bcd1 (
        .clk     (clk),
        .rs      (rs),
        .i_start (w_start),
        .i_bin   (counter1),
        .o_bcd   (w_bcd1),
        .o_done  (w_done1)
    );

    bin2bcd_seq u_bcd2 (
        .clk     (clk),
        .rs      (rs),
        .i_start (w_start),
        .i_bin   (counter2),
        .o_bcd   (w_bcd2),
        .o_done  (w_done2)
    );

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            r_state <= LOAD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        unique case (r_state)
            LOAD: begin
                w_start     = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_cnt_nxt = r_cnt + 3'd1;
                if (r_cnt == 3'd7) w_state_nxt = UPDATE;
            end
            UPDATE: w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    assign w_wr = (r_state == UPDATE) && w_done1 && w_done2;

    assign w_disp1_nxt = w_wr ? w_bcd1 : r_disp1;
    assign w_disp2_nxt = w_wr ? w_bcd2 : r_disp2;

    assign w_presc_nxt = (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
    assign w_dig_nxt   = (r_presc == PRESC_MAX) ? r_dig + 2'd1 : r_dig;

    // Outputs are decoded from next-state values so the registered
    // an/seg line up with the prescaler/index they belong to.
    assign w_an_sel = ~(4'b1000 >> w_dig_nxt);

    always_comb begin
        w_sel = w_disp2_nxt;
        if (w_dig_nxt == DIG_R1_TENS || w_dig_nxt == DIG_R1_ONES)
            w_sel = w_disp1_nxt;
        w_tens_slot = (w_dig_nxt == DIG_R1_TENS) ||
                      (w_dig_nxt == DIG_R2_TENS);
        w_digit = w_tens_slot ? w_sel[7:4] : w_sel[3:0];
        w_an    = 4'b1111;
        w_seg   = SEG_BLANK;
        // Prescaler slot 0 stays dark to hide segment transitions.
        if (w_presc_nxt != '0) begin
            if (w_sel[11:8] != 4'd0) begin
                w_an  = w_an_sel;
                w_seg = SEG_DASH;
            end else if (!(w_tens_slot && (BLANK_LEADING != 0) &&
                           (w_sel[7:4] == 4'd0))) begin
                w_an  = w_an_sel;
                w_seg = seg_of(w_digit);
            end
        end
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            r_disp1 <= '0;
            r_disp2 <= '0;
            r_presc <= '0;
            r_dig   <= DIG_R1_TENS;
            r_an    <= 4'b1111;
            r_seg   <= SEG_BLANK;
            r_upd   <= 1'b0;
        end else begin
            r_disp1 <= w_disp1_nxt;
            r_disp2 <= w_disp2_nxt;
            r_presc <= w_presc_nxt;
            r_dig   <= w_dig_nxt;
            r_an    <= w_an;
            r_seg   <= w_seg;
            r_upd   <= w_wr;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;
    assign upd = r_upd;

endmodule

// File: doc/traffic_display.md
Name: traffic_display

Overview:
- Display stage directly downstream of the two-road traffic light controller.
- Consumes its two 8-bit binary countdown values and shows them on a 4-digit multiplexed common-anode 7-segment display: road 1 on the left pair, road 2 on the right pair.
- Contains a continuously running sequential binary-to-BCD converter and a digit-scan multiplexer.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is enabled. Must be ≥ 2; benches use 4.
- BLANK_LEADING, 1, when 1 a tens digit of 0 is blanked.

Ports:
- clk, in, 1, system clock.
- rs, in, 1, reset: asynchronous, active-high.
- counter1, in, 8, road 1 remaining seconds, binary.
- counter2, in, 8, road 2 remaining seconds, binary.
- an, out, 4, digit enables, active-low. an[3]=road1 tens, an[2]=road1 ones, an[1]=road2 tens, an[0]=road2 ones.
- seg, out, 7, segments {g,f,e,d,c,b,a}, active-low.
- dp, out, 1, decimal point, active-low; held 1.
- upd, out, 1, one-cycle pulse when the displayed values are refreshed.

Behaviour:
- Reset (async assert, sync release):
  - an=4'b1111, seg=7'b1111111, dp=1, upd=0.
  - Prescaler=0, digit index=0 (an[3]).
  - Display BCD registers=0, converter in LOAD.
- Converter FSM: LOAD -> SHIFT (8 cycles) -> UPDATE -> LOAD, looping forever, one full pass every 10 cycles.
  - LOAD: snapshot counter1 and counter2. Input changes after LOAD are ignored until the next LOAD.
  - SHIFT: shift-add-3 double-dabble on both values in parallel, 8 iterations, one per cycle. 12-bit BCD result each (hundreds, tens, ones).
  - UPDATE: write both results to the display registers; upd=1 for exactly this cycle.
  - Input-to-display latency is at most 20 cycles.
- Out of range: if a value's hundreds digit is nonzero (value > 99), both digits of that road show dash (seg=7'b0111111). The other road is unaffected.
- Scan: the prescaler counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 3 -> 2 -> 1 -> 0 -> 3 (an[3] first).
  - Anti-ghost: in the cycle where prescaler==0, an=4'b1111 and seg=7'b1111111. For the remaining SCAN_DIV-1 cycles, the selected an bit is 0.
- Leading blank: with BLANK_LEADING=1, tens==0 and hundreds==0 -> that tens digit has an bit 1 and seg all 1 for its whole slot. Ones digit is always shown, so 0 displays as "0".
- Segment encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- All outputs are registered; no combinational path from counter1/counter2 to outputs.
- Reset mid-conversion or mid-scan: immediate return to reset values; the next upd occurs exactly 10 cycles after release.

Decomposition:
- Package traffic_pkg holds:
  - SEG_DIGIT[0:9], SEG_DASH, SEG_BLANK constants.
  - Digit-index constants for the four positions.
  - Converter state enum {LOAD, SHIFT, UPDATE}.
- Sub-module bin2bcd_seq: one 8-bit sequential double-dabble with start/done. Instantiate twice, both started in LOAD.
- Scan counter and segment mux stay in the top.

Test Plan:
- Reset, then counter1=15, counter2=20, SCAN_DIV=4.
  - After the first upd, one scan frame gives: an=0111/seg=1111001; an=1011/seg=0010010; an=1101/seg=0100100; an=1110/seg=1000000.
  - Each slot is preceded by one all-off cycle.
- counter1=5, counter2=0, BLANK_LEADING=1:
  - an[3] and an[1] slots show an=1111, seg=1111111.
  - an[2] shows seg=0010010; an[0] shows seg=1000000.
- counter1=150, counter2=99: road 1 digits show seg=0111111; road 2 digits both show seg=0010000.
- counter1 changes 15->14 one cycle after LOAD: the next upd still shows 15; the following upd shows 14. upd pulses are exactly 10 cycles apart.
- Assert rs mid-SHIFT and mid-scan slot:
  - Outputs go to reset values in the same cycle without waiting for a clock.
  - After release, upd occurs exactly 10 cycles later and the scan restarts at an[3].
- Sweep counter1 0..255 with counter2 fixed: displayed tens/ones match value/10 and value%10 for ≤99, and dashes for ≥100.
